// File: rtl/ram_pkg.sv
// Shared types and helpers for the arbitrated multi-channel RAM.
package ram_pkg;

    typedef enum logic [0:0] {
        CLEAR,
        RUN
    } ram_state_e;

    // Width of a channel index; never below one bit so N_CH=1 still has a legal vector.
    function automatic int unsigned ch_idx_w(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, priority starts after the last grant.
module rr_arbiter import ram_pkg::*; #(
    parameter int unsigned N_CH = 2,
    localparam int unsigned IdxW = ch_idx_w(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req_i,
    input  logic            adv_i,
    output logic [N_CH-1:0] gnt_o,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] last_q;
    logic            any;
    int              rank;
    int              best;

    // Rank 0 is the channel right after the last grant; lowest requesting rank wins.
    always_comb begin
        idx_o = '0;
        best  = int'(N_CH);
        rank  = 0;
        for (int i = 0; i < int'(N_CH); i++) begin
            rank = (i + int'(N_CH) - 1 - int'(last_q)) % int'(N_CH);
            if (req_i[i] && (rank < best)) begin
                best  = rank;
                idx_o = IdxW'(i);
            end
        end
        any = (best < int'(N_CH));
    end

    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            gnt_o[i] = any && (idx_o == IdxW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IdxW'(N_CH - 1);
        end else if (adv_i && any) begin
            last_q <= idx_o;
        end
    end

endmodule

// File: rtl/ram_arb.sv
// Multi-channel synchronous RAM with round-robin req/gnt access, one-cycle pipelined
// reads on a shared return bus and an optional zeroing sweep after reset.
module ram_arb import ram_pkg::*; #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DEPTH          = 2**ADDR_W,
    parameter int unsigned N_CH           = 2,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          req_i,
    input  logic [N_CH-1:0]          we_i,
    input  logic [N_CH*ADDR_W-1:0]   addr_i,
    input  logic [N_CH*DATA_W-1:0]   wdata_i,
    output logic [N_CH-1:0]          gnt_o,
    output logic [N_CH-1:0]          rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     data_oe_o,
    output logic                     busy_o
);

    localparam int unsigned IdxW  = ch_idx_w(N_CH);
    localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ram_state_e        state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic [N_CH-1:0]   rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              run;
    logic [N_CH-1:0]   gnt;
    logic [IdxW-1:0]   gnt_idx;
    logic              xfer;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;

    assign run = (state_q == RUN);

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req_i & {N_CH{run}}),
        .adv_i (run),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign xfer      = |gnt;
    assign sel_we    = we_i[gnt_idx];
    assign sel_addr  = addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
    // Extra bit so DEPTH == 2**ADDR_W compares correctly.
    assign in_range  = ({1'b0, sel_addr} < (ADDR_W+1)'(DEPTH));
    assign rd_word   = in_range ? mem_q[sel_addr[MemAw-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (!run) begin
            mem_q[clr_addr_q[MemAw-1:0]] <= '0;
        end else if (xfer && sel_we && in_range) begin
            mem_q[sel_addr[MemAw-1:0]] <= sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_addr_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            busy_q     <= CLEAR_ON_RESET;
        end else begin
            rvalid_q <= '0;
            unique case (state_q)
                CLEAR: begin
                    if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b0;
                        clr_addr_q <= '0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                RUN: begin
                    // rdata_q keeps its last value between responses.
                    if (xfer && !sel_we) begin
                        rvalid_q <= gnt;
                        rdata_q  <= rd_word;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign gnt_o     = gnt;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign data_oe_o = |rvalid_q;
    assign busy_o    = busy_q;

endmodule
